// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - framed byte stream to instruction memory word writer
//
// Receives frames of the form 0xA5 | CNT_LO | CNT_HI | CNT x 4 data bytes | CHK.
// Data bytes are packed into 32-bit words with the first byte in the least
// significant position. Each word is written to BASE_ADDR + 4*index.
// CHK is the XOR of every byte after the 0xA5 header.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_data    byte stream input
//   in_ready             byte accepted when in_valid & in_ready
//   start                re-arm pulse, honoured only after a frame ends (DONE/ERR)
//   mem_we, mem_addr,    one-cycle word write to the instruction memory
//   mem_wdata
//   busy                 a frame is in progress (header seen, CHK not yet seen)
//   done, error          frame result, held until start
module instr_mem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W   = $clog2(DEPTH + 1);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [7:0]  SYNC    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state;
    logic [15:0]        count;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         byte_cnt;
    logic [23:0]        word;     // lower three bytes; the fourth comes straight from in_data
    logic [7:0]         acc;
    logic               xfer;
    logic [15:0]        count_new;

    assign xfer      = in_valid & in_ready;
    assign count_new = {in_data, count[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            idx       <= '0;
            byte_cnt  <= '0;
            word      <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Anything other than the sync byte is junk and is dropped.
                    if (xfer && in_data == SYNC) begin
                        state <= ST_CNT_LO;
                        busy  <= 1'b1;
                    end
                end
                ST_CNT_LO: begin
                    if (xfer) begin
                        count[7:0] <= in_data;
                        acc        <= acc ^ in_data;
                        state      <= ST_CNT_HI;
                    end
                end
                ST_CNT_HI: begin
                    if (xfer) begin
                        count[15:8] <= in_data;
                        acc         <= acc ^ in_data;
                        byte_cnt    <= '0;
                        // Rejecting oversize counts here keeps idx from ever wrapping.
                        if ({1'b0, count_new} > DEPTH_W) begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (count_new == 16'd0) begin
                            state <= ST_CHK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        acc      <= acc ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {in_data, word};
                            mem_addr  <= BASE_ADDR + (64'(idx) << 2);
                            idx       <= idx + 1'b1;
                            if (16'(idx) + 16'd1 == count)
                                state <= ST_CHK;
                        end else begin
                            word[{byte_cnt, 3'b000} +: 8] <= in_data;
                        end
                    end
                end
                ST_CHK: begin
                    if (xfer) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        if (in_data == acc) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_IDLE;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        idx      <= '0;
                        acc      <= '0;
                        byte_cnt <= '0;
                        mem_addr <= BASE_ADDR;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - directed self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] wr_addr[$];
    logic [31:0] wr_data[$];

    logic [7:0] frame1[12] = '{8'hA5, 8'h02, 8'h00, 8'h67, 8'h45, 8'h23, 8'h01,
                               8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h02};
    logic [7:0] frame2[9]  = '{8'h33, 8'hA5, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB,
                               8'hAA, 8'h01};

    instr_mem_loader #(.DEPTH(64), .BASE_ADDR(64'h0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Presents one byte for exactly one cycle; optional idle gap first.
    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame1(input logic [7:0] chk, input bit gaps);
        for (int i = 0; i < 11; i++) send_byte(frame1[i], gaps ? int'($urandom_range(0, 2)) : 0);
        send_byte(chk, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_frame1_writes(input string tag);
        check({tag, " nwr"}, 64'(wr_addr.size()), 64'd2);
        if (wr_addr.size() == 2) begin
            check({tag, " a0"}, wr_addr[0], 64'h0);
            check({tag, " d0"}, 64'(wr_data[0]), 64'h01234567);
            check({tag, " a1"}, wr_addr[1], 64'h4);
            check({tag, " d1"}, 64'(wr_data[1]), 64'h89ABCDEF);
        end
    endtask

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", mem_addr, 64'h0);
        check("rst mem_wdata", 64'(mem_wdata), 64'h0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done/err", 64'({done, error}), 64'd0);
        rst_n = 1'b1;

        // Test 1: two-word frame
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("t1 busy", 64'(busy), 64'd1);
        for (int i = 1; i < 12; i++) send_byte(frame1[i], 0);
        @(negedge clk);
        check_frame1_writes("t1");
        check("t1 done", 64'(done), 64'd1);
        check("t1 error", 64'(error), 64'd0);
        check("t1 in_ready", 64'(in_ready), 64'd0);
        check("t1 busy", 64'(busy), 64'd0);
        pulse_start();
        @(negedge clk);
        check("t1 restart", 64'({in_ready, done, error}), 64'b100);
        check("t1 addr base", mem_addr, 64'h0);

        // Test 2: leading junk then one word
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 9; i++) send_byte(frame2[i], 0);
        @(negedge clk);
        check("t2 nwr", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() == 1) begin
            check("t2 a0", wr_addr[0], 64'h0);
            check("t2 d0", 64'(wr_data[0]), 64'hAABBCCDD);
        end
        check("t2 done", 64'({done, error}), 64'b10);
        pulse_start();

        // Test 3: bad checksum
        wr_addr.delete(); wr_data.delete();
        send_frame1(8'h03, 1'b0);
        @(negedge clk);
        check_frame1_writes("t3");
        check("t3 result", 64'({done, error}), 64'b01);
        pulse_start();
        @(negedge clk);
        check("t3 cleared", 64'({in_ready, done, error}), 64'b100);

        // Test 4: oversize count, then empty frame
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5, 0); send_byte(8'h41, 0); send_byte(8'h00, 0);
        @(negedge clk);
        check("t4 ovf error", 64'({done, error, busy, in_ready}), 64'b0100);
        pulse_start();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk);
        check("t4 zero busy", 64'(busy), 64'd1);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("t4 zero done", 64'({done, error}), 64'b10);
        check("t4 nwr", 64'(wr_addr.size()), 64'd0);
        pulse_start();

        // Test 5: stalled frame, then bytes offered while DONE
        wr_addr.delete(); wr_data.delete();
        send_frame1(8'h02, 1'b1);
        @(negedge clk);
        check_frame1_writes("t5");
        check("t5 done", 64'({done, error}), 64'b10);
        for (int i = 0; i < 4; i++) send_byte(8'hA5, 0);
        @(negedge clk);
        check("t5 held", 64'({done, in_ready, busy}), 64'b100);
        pulse_start();
        @(negedge clk);
        check("t5 idle", 64'({busy, in_ready}), 64'b01);

        // Test 6: reset mid-frame, then full resend
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 5; i++) send_byte(frame1[i], 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6 rst busy", 64'({busy, done, error}), 64'b000);
        check("t6 rst in_ready", 64'({in_ready, mem_we}), 64'b10);
        check("t6 rst addr", mem_addr, 64'h0);
        check("t6 rst wdata", 64'(mem_wdata), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame1(8'h02, 1'b0);
        @(negedge clk);
        check_frame1_writes("t6");
        check("t6 done", 64'({done, error}), 64'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
